// File: rtl/mac_tile_sequencer.sv
// Tile sequencer for the 4x4 MAC array: walks output tiles (mt outer, tt inner),
// streams I/W reads, strobes clear/accumulate and writes the finished rows back.
module mac_tile_sequencer #(
  parameter int DW      = 16,
  parameter int LANES   = 4,
  parameter int MEM_LAT = 1
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                START,
  input  logic [11:0]         MNT,
  output logic                BUSY,
  output logic                DONE,
  output logic                ERR,
  output logic                EN_I,
  output logic [2:0]          ADDR_I,
  output logic                EN_W,
  output logic [2:0]          ADDR_W,
  output logic                ACC_CLR,
  output logic                ACC_EN,
  output logic [1:0]          ROW_SEL,
  input  logic [DW*LANES-1:0] ROW_DATA,
  output logic                EN_O,
  output logic                RW_O,
  output logic [3:0]          ADDR_O,
  output logic [DW*LANES-1:0] WDATA_O
);

  localparam int DCW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DRAIN, S_WB, S_NEXT, S_DONE, S_ERR
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         m_q, m_d, n_q, n_d, t_q, t_d;
  logic               mt_q, mt_d, tt_q, tt_d;
  logic [1:0]         k_q, k_d, r_q, r_d;
  logic [DCW-1:0]     dcnt_q, dcnt_d;
  logic               busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic               en_i_q, en_i_d, acc_clr_q, acc_clr_d, en_o_q, en_o_d;
  logic [2:0]         addr_i_q, addr_i_d, addr_w_q, addr_w_d;
  logic [1:0]         row_sel_q, row_sel_d;
  logic [3:0]         addr_o_q, addr_o_d;
  logic [MEM_LAT-1:0] acc_sh_q, acc_sh_d;
  logic [MEM_LAT:0]   acc_sh_w;
  logic               legal;
  logic [3:0]         rv_m1;
  logic [DW*LANES-1:0] wdata;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    n_d     = n_q;
    t_d     = t_q;
    mt_d    = mt_q;
    tt_d    = tt_q;
    k_d     = k_q;
    r_d     = r_q;
    dcnt_d  = dcnt_q;

    legal = (MNT[11:8] >= 4'd1) && (MNT[11:8] <= 4'd8) &&
            (MNT[7:4]  >= 4'd1) && (MNT[7:4]  <= 4'd4) &&
            (MNT[3:0]  >= 4'd1) && (MNT[3:0]  <= 4'd8);
    // Last valid row index of the current row tile, i.e. min(4, M - mt*4) - 1
    rv_m1 = mt_q ? (m_q - 4'd5) : ((m_q >= 4'd4) ? 4'd3 : (m_q - 4'd1));

    case (state_q)
      S_IDLE: if (START) begin
        m_d  = MNT[11:8];
        n_d  = MNT[7:4];
        t_d  = MNT[3:0];
        mt_d = 1'b0;
        tt_d = 1'b0;
        k_d  = 2'd0;
        state_d = legal ? S_LOAD : S_ERR;
      end
      S_LOAD: begin
        if (k_q == 2'(n_q - 4'd1)) begin
          dcnt_d  = '0;
          state_d = S_DRAIN;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      S_DRAIN: begin
        if (dcnt_q == DCW'(MEM_LAT - 1)) begin
          r_d     = 2'd0;
          state_d = S_WB;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      S_WB: begin
        if (r_q == rv_m1[1:0]) state_d = S_NEXT;
        else                   r_d = r_q + 2'd1;
      end
      S_NEXT: begin
        k_d = 2'd0;
        if (tt_q != (t_q > 4'd4)) begin
          tt_d    = 1'b1;
          state_d = S_LOAD;
        end else if (mt_q != (m_q > 4'd4)) begin
          mt_d    = 1'b1;
          tt_d    = 1'b0;
          state_d = S_LOAD;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are derived from the next state.
    busy_d    = (state_d == S_LOAD) || (state_d == S_DRAIN) ||
                (state_d == S_WB)   || (state_d == S_NEXT);
    done_d    = (state_d == S_DONE);
    err_d     = (state_d == S_ERR);
    en_i_d    = (state_d == S_LOAD);
    acc_clr_d = en_i_d && (k_d == 2'd0);
    addr_i_d  = en_i_d ? {mt_d, k_d} : 3'd0;
    addr_w_d  = en_i_d ? {tt_d, k_d} : 3'd0;
    en_o_d    = (state_d == S_WB);
    row_sel_d = en_o_d ? r_d : 2'd0;
    addr_o_d  = en_o_d ? {mt_d, tt_d, r_d} : 4'd0;

    acc_sh_w = {acc_sh_q, en_i_q};
    acc_sh_d = acc_sh_w[MEM_LAT-1:0];
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= S_IDLE;
      m_q       <= '0;
      n_q       <= '0;
      t_q       <= '0;
      mt_q      <= 1'b0;
      tt_q      <= 1'b0;
      k_q       <= '0;
      r_q       <= '0;
      dcnt_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      en_i_q    <= 1'b0;
      acc_clr_q <= 1'b0;
      addr_i_q  <= '0;
      addr_w_q  <= '0;
      en_o_q    <= 1'b0;
      row_sel_q <= '0;
      addr_o_q  <= '0;
      acc_sh_q  <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      n_q       <= n_d;
      t_q       <= t_d;
      mt_q      <= mt_d;
      tt_q      <= tt_d;
      k_q       <= k_d;
      r_q       <= r_d;
      dcnt_q    <= dcnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      en_i_q    <= en_i_d;
      acc_clr_q <= acc_clr_d;
      addr_i_q  <= addr_i_d;
      addr_w_q  <= addr_w_d;
      en_o_q    <= en_o_d;
      row_sel_q <= row_sel_d;
      addr_o_q  <= addr_o_d;
      acc_sh_q  <= acc_sh_d;
    end
  end

  // ROW_DATA follows ROW_SEL combinationally; lanes past column T are zeroed.
  always_comb begin
    wdata = ROW_DATA;
    for (int c = 0; c < LANES; c++) begin
      if (int'(tt_q) * LANES + c >= int'(t_q)) wdata[c*DW +: DW] = '0;
    end
  end

  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign ERR     = err_q;
  assign EN_I    = en_i_q;
  assign ADDR_I  = addr_i_q;
  assign EN_W    = en_i_q;
  assign ADDR_W  = addr_w_q;
  assign ACC_CLR = acc_clr_q;
  assign ACC_EN  = acc_sh_q[MEM_LAT-1];
  assign ROW_SEL = row_sel_q;
  assign EN_O    = en_o_q;
  assign RW_O    = en_o_q;
  assign ADDR_O  = addr_o_q;
  assign WDATA_O = en_o_q ? wdata : '0;

endmodule

// File: tb/tb_mac_tile_sequencer.sv
// Bench for mac_tile_sequencer: builds the expected per-cycle output trace of each
// job from the tiling rules and compares every cycle against the DUT.
module tb_mac_tile_sequencer;
  localparam int MEM_LAT = 1;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [11:0] mnt = '0;
  logic        busy, done, err, en_i, en_w, acc_clr, acc_en, en_o, rw_o;
  logic [2:0]  addr_i, addr_w;
  logic [1:0]  row_sel;
  logic [3:0]  addr_o;
  logic [63:0] row_data, wdata_o;
  logic [63:0] rows [4];

  assign row_data = rows[row_sel];

  mac_tile_sequencer #(.DW(16), .LANES(4), .MEM_LAT(MEM_LAT)) dut (
    .CLK(clk), .RSTN(rstn), .START(start), .MNT(mnt),
    .BUSY(busy), .DONE(done), .ERR(err),
    .EN_I(en_i), .ADDR_I(addr_i), .EN_W(en_w), .ADDR_W(addr_w),
    .ACC_CLR(acc_clr), .ACC_EN(acc_en), .ROW_SEL(row_sel), .ROW_DATA(row_data),
    .EN_O(en_o), .RW_O(rw_o), .ADDR_O(addr_o), .WDATA_O(wdata_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        busy, done, err, en_i;
    logic [2:0]  addr_i;
    logic        en_w;
    logic [2:0]  addr_w;
    logic        acc_clr, acc_en, en_o, rw_o;
    logic [1:0]  row_sel;
    logic [3:0]  addr_o;
    logic [63:0] wdata;
  } obs_t;

  typedef struct {
    logic [11:0] mnt;
    bit          legal;
    int          pidx;   // -1 none, -2 pulse in the DONE cycle, else trace index
    logic [11:0] pmnt;
  } vec_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  function automatic obs_t sample();
    obs_t o;
    o.busy = busy; o.done = done; o.err = err; o.en_i = en_i; o.addr_i = addr_i;
    o.en_w = en_w; o.addr_w = addr_w; o.acc_clr = acc_clr; o.acc_en = acc_en;
    o.en_o = en_o; o.rw_o = rw_o; o.row_sel = row_sel; o.addr_o = addr_o;
    o.wdata = wdata_o;
    return o;
  endfunction

  task automatic check(input obs_t exp, input string name, input int idx);
    obs_t act;
    act = sample();
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, want %h", name, idx, act, exp);
    end
  endtask

  task automatic build_trace(input logic [11:0] m_n_t, input bit legal);
    int   m, n, t, rv;
    obs_t o;
    logic [63:0] w;
    m = int'(m_n_t[11:8]); n = int'(m_n_t[7:4]); t = int'(m_n_t[3:0]);
    exp_q.delete();
    if (!legal) begin
      o = '0; o.err = 1'b1; exp_q.push_back(o);
    end else begin
      for (int mt = 0; mt < (m + 3) / 4; mt++) begin
        for (int tt = 0; tt < (t + 3) / 4; tt++) begin
          for (int k = 0; k < n; k++) begin
            o = '0; o.busy = 1'b1; o.en_i = 1'b1; o.en_w = 1'b1;
            o.addr_i = 3'(mt * 4 + k); o.addr_w = 3'(tt * 4 + k);
            o.acc_clr = (k == 0);
            exp_q.push_back(o);
          end
          for (int d = 0; d < MEM_LAT; d++) begin
            o = '0; o.busy = 1'b1; exp_q.push_back(o);
          end
          rv = (m - mt * 4 < 4) ? m - mt * 4 : 4;
          for (int r = 0; r < rv; r++) begin
            w = rows[r];
            for (int c = 0; c < 4; c++) if (tt * 4 + c >= t) w[c*16 +: 16] = 16'h0;
            o = '0; o.busy = 1'b1; o.en_o = 1'b1; o.rw_o = 1'b1;
            o.row_sel = 2'(r); o.addr_o = 4'(mt * 8 + tt * 4 + r); o.wdata = w;
            exp_q.push_back(o);
          end
          o = '0; o.busy = 1'b1; exp_q.push_back(o);
        end
      end
      o = '0; o.done = 1'b1; exp_q.push_back(o);
      for (int i = exp_q.size() - 1; i >= MEM_LAT; i--)
        exp_q[i].acc_en = exp_q[i - MEM_LAT].en_i;
    end
    o = '0; exp_q.push_back(o);
  endtask

  task automatic run_job(input vec_t v, input string name);
    for (int i = 0; i < 4; i++) rows[i] = {$urandom, $urandom} | 64'h0001_0001_0001_0001;
    build_trace(v.mnt, v.legal);
    @(negedge clk); start = 1'b1; mnt = v.mnt;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      start = 1'b0;
      check(exp_q[i], name, i);
      if (i == v.pidx || (v.pidx == -2 && exp_q[i].done)) begin
        start = 1'b1; mnt = v.pmnt;
      end
    end
  endtask

  vec_t vecs[$];
  vec_t rv_vec;
  int   cnt;

  initial begin
    vecs.push_back('{12'h444, 1'b1, -1, 12'h000});
    vecs.push_back('{12'h828, 1'b1, -1, 12'h000});
    vecs.push_back('{12'h536, 1'b1, -1, 12'h000});
    vecs.push_back('{12'h050, 1'b0, -1, 12'h000});
    vecs.push_back('{12'h454, 1'b0, -1, 12'h000});
    vecs.push_back('{12'h444, 1'b1, -1, 12'h000});
    vecs.push_back('{12'h904, 1'b0, -1, 12'h000});
    vecs.push_back('{12'h419, 1'b0, -1, 12'h000});
    vecs.push_back('{12'h828, 1'b1,  3, 12'h111});
    vecs.push_back('{12'h444, 1'b1, -2, 12'h111});
    vecs.push_back('{12'h111, 1'b1, -1, 12'h000});
    vecs.push_back('{12'h848, 1'b1, -1, 12'h000});

    for (int i = 0; i < 4; i++) rows[i] = '0;
    repeat (2) @(negedge clk);
    check('0, "reset", 0);
    rstn = 1'b1;
    @(negedge clk);
    check('0, "idle", 0);

    for (int i = 0; i < vecs.size(); i++) run_job(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 10; i++) begin
      rv_vec.mnt  = {4'($urandom_range(1, 8)), 4'($urandom_range(1, 4)), 4'($urandom_range(1, 8))};
      rv_vec.legal = 1'b1;
      rv_vec.pidx = -1;
      rv_vec.pmnt = '0;
      run_job(rv_vec, $sformatf("rand%0d", i));
    end

    // Abort in the middle of write-back, then a full job must still run cleanly.
    @(negedge clk); start = 1'b1; mnt = 12'h444;
    @(negedge clk); start = 1'b0;
    cnt = 0;
    while (!en_o && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    n_cmp++;
    if (!en_o) begin
      n_fail++;
      $display("FAIL wb_wait: got no EN_O after %0d cycles, want write-back", cnt);
    end
    @(posedge clk); #2;
    rstn = 1'b0;
    #1 check('0, "rst_mid", 0);
    @(negedge clk); rstn = 1'b1;
    check('0, "rst_rel", 0);
    run_job('{12'h444, 1'b1, -1, 12'h000}, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
